// File: rtl/bmp_stream_writer.sv
// Serialises 32-bit {B,G,R,pad} pixel words into a byte stream forming a 24-bit BMP image.
// Optional feature macro BMPW_HEADER_EN: when defined, the 54-byte BMP header precedes the pixel data.
module bmp_stream_writer #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        in_rd_en,
    input  logic [31:0] in_dout,
    input  logic        in_empty,
    output logic        out_wr_en,
    output logic [7:0]  out_din,
    input  logic        out_full,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] ROW_BYTES = 32'(3 * WIDTH);
    localparam logic [31:0] PAD_BYTES = (32'd4 - (ROW_BYTES % 32'd4)) % 32'd4;
    localparam logic [31:0] IMG_SIZE  = (ROW_BYTES + PAD_BYTES) * 32'(HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
    localparam logic [11:0] LAST_COL  = 12'(WIDTH - 1);
    localparam logic [11:0] LAST_ROW  = 12'(HEIGHT - 1);
    localparam logic [1:0]  LAST_PAD  = 2'(PAD_BYTES - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        PIX,
        PAD,
        FIN
    } state_t;

    state_t      state, state_next;
    logic [11:0] col, col_next;
    logic [11:0] row, row_next;
    logic [1:0]  byte_idx, byte_idx_next;
    logic [1:0]  pad_cnt, pad_cnt_next;
    logic [23:0] pix_reg, pix_next;
    logic        row_end;

    // The pad byte of each pixel word carries no image data.
    logic unused_pad;
    assign unused_pad = ^in_dout[7:0];

`ifdef BMPW_HEADER_EN
    logic [5:0] hdr_idx, hdr_idx_next;

    function automatic logic [7:0] header_byte(input logic [5:0] idx);
        logic [31:0] w;
        logic [5:0]  base;
        logic [1:0]  lane;
        logic [7:0]  b;
        w    = '0;
        base = 6'd0;
        if      (idx <= 6'd1)  base = 6'd0;
        else if (idx <= 6'd5)  begin w = FILE_SIZE;          base = 6'd2;  end
        else if (idx <= 6'd9)  base = 6'd6;
        else if (idx <= 6'd13) begin w = 32'd54;             base = 6'd10; end
        else if (idx <= 6'd17) begin w = 32'd40;             base = 6'd14; end
        else if (idx <= 6'd21) begin w = 32'(WIDTH);         base = 6'd18; end
        else if (idx <= 6'd25) begin w = 32'(HEIGHT);        base = 6'd22; end
        else if (idx <= 6'd27) begin w = 32'd1;              base = 6'd26; end
        else if (idx <= 6'd29) begin w = 32'd24;             base = 6'd28; end
        else if (idx <= 6'd33) base = 6'd30;
        else if (idx <= 6'd37) begin w = IMG_SIZE;           base = 6'd34; end
        else if (idx <= 6'd41) begin w = 32'd2835;           base = 6'd38; end
        else if (idx <= 6'd45) begin w = 32'd2835;           base = 6'd42; end
        else                   base = 6'd46;
        lane = 2'(idx - base);
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        // The magic number is the only non-numeric field.
        if (idx == 6'd0)      b = 8'h42;
        else if (idx == 6'd1) b = 8'h4D;
        return b;
    endfunction
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            byte_idx <= '0;
            pad_cnt  <= '0;
            pix_reg  <= '0;
`ifdef BMPW_HEADER_EN
            hdr_idx  <= '0;
`endif
        end else begin
            state    <= state_next;
            col      <= col_next;
            row      <= row_next;
            byte_idx <= byte_idx_next;
            pad_cnt  <= pad_cnt_next;
            pix_reg  <= pix_next;
`ifdef BMPW_HEADER_EN
            hdr_idx  <= hdr_idx_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_next    = state;
        col_next      = col;
        row_next      = row;
        byte_idx_next = byte_idx;
        pad_cnt_next  = pad_cnt;
        pix_next      = pix_reg;
        row_end       = 1'b0;
        in_rd_en      = 1'b0;
        out_wr_en     = 1'b0;
        out_din       = 8'h00;
        done          = 1'b0;
        busy          = (state != IDLE) && (state != FIN);
`ifdef BMPW_HEADER_EN
        hdr_idx_next  = hdr_idx;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    col_next = '0;
                    row_next = '0;
`ifdef BMPW_HEADER_EN
                    hdr_idx_next = '0;
                    state_next   = HEADER;
`else
                    state_next   = LOAD;
`endif
                end
            end

`ifdef BMPW_HEADER_EN
            HEADER: begin
                out_din   = header_byte(hdr_idx);
                out_wr_en = !out_full;
                if (!out_full) begin
                    if (hdr_idx == 6'd53) state_next = LOAD;
                    else                  hdr_idx_next = hdr_idx + 6'd1;
                end
            end
`endif

            LOAD: begin
                if (!in_empty) begin
                    in_rd_en      = 1'b1;
                    pix_next      = in_dout[31:8];
                    byte_idx_next = '0;
                    state_next    = PIX;
                end
            end

            PIX: begin
                out_wr_en = !out_full;
                case (byte_idx)
                    2'd0:    out_din = pix_reg[23:16];
                    2'd1:    out_din = pix_reg[15:8];
                    default: out_din = pix_reg[7:0];
                endcase
                if (!out_full) begin
                    if (byte_idx == 2'd2) begin
                        if (col == LAST_COL) begin
                            if (PAD_BYTES != 32'd0) begin
                                pad_cnt_next = '0;
                                state_next   = PAD;
                            end else begin
                                row_end = 1'b1;
                            end
                        end else begin
                            col_next   = col + 12'd1;
                            state_next = LOAD;
                        end
                    end else begin
                        byte_idx_next = byte_idx + 2'd1;
                    end
                end
            end

            PAD: begin
                out_wr_en = !out_full;
                if (!out_full) begin
                    if (pad_cnt == LAST_PAD) row_end = 1'b1;
                    else                     pad_cnt_next = pad_cnt + 2'd1;
                end
            end

            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase

        // Row wrap is shared by the padded and unpadded row endings.
        if (row_end) begin
            col_next   = '0;
            row_next   = row + 12'd1;
            state_next = (row == LAST_ROW) ? FIN : LOAD;
        end
    end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Self-checking bench for bmp_stream_writer: FIFO models on both sides and a byte-list reference of the BMP stream.
module tb_bmp_stream_writer;

    localparam int W         = 5;
    localparam int H         = 3;
    localparam int ROW_BYTES = 3 * W;
    localparam int PADB      = (4 - (ROW_BYTES % 4)) % 4;
    localparam int IMG       = (ROW_BYTES + PADB) * H;
    localparam int NPIX      = W * H;
`ifdef BMPW_HEADER_EN
    localparam int HDR       = 54;
`else
    localparam int HDR       = 0;
`endif
    localparam int BUDGET    = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_rd_en;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        out_wr_en;
    logic [7:0]  out_din;
    logic        out_full = 1'b0;
    logic        busy;
    logic        done;

    bmp_stream_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_rd_en (in_rd_en),
        .in_dout  (in_dout),
        .in_empty (in_empty),
        .out_wr_en(out_wr_en),
        .out_din  (out_din),
        .out_full (out_full),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Show-ahead pixel FIFO: entries below avail are present, rd_ptr is the head.
    logic [31:0] pix_mem [0:1023];
    int          avail = 0;
    int          rd_ptr = 0;
    assign in_dout  = pix_mem[rd_ptr[9:0]];
    assign in_empty = (rd_ptr >= avail);

    // Byte sink plus event counters.
    logic [7:0] out_mem [0:4095];
    int         out_cnt = 0;
    int         done_cnt = 0;
    int         bad_pop = 0;
    int         bad_wr = 0;

    always @(posedge clk) begin
        if (out_wr_en) begin
            out_mem[out_cnt[11:0]] <= out_din;
            out_cnt <= out_cnt + 1;
            if (out_full) bad_wr <= bad_wr + 1;
        end
        if (in_rd_en) begin
            rd_ptr <= rd_ptr + 1;
            if (in_empty) bad_pop <= bad_pop + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int         vectors = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push32(input int v);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(v >> (8 * k)));
    endtask

    // Reference stream: header fields then rows of B,G,R bytes padded to a 4-byte multiple.
    task automatic build_expected(input int base);
        logic [31:0] p;
        exp_q.delete();
`ifdef BMPW_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push32(54 + IMG);
        push32(0);
        push32(54);
        push32(40);
        push32(W);
        push32(H);
        exp_q.push_back(8'd1);  exp_q.push_back(8'd0);
        exp_q.push_back(8'd24); exp_q.push_back(8'd0);
        push32(0);
        push32(IMG);
        push32(2835);
        push32(2835);
        push32(0);
        push32(0);
`endif
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = pix_mem[(base + r * W + c) % 1024];
                exp_q.push_back(p[31:24]);
                exp_q.push_back(p[23:16]);
                exp_q.push_back(p[15:8]);
            end
            for (int k = 0; k < PADB; k++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic load_frame(output int base, input int n_avail);
        logic [31:0] spec_vals [4];
        spec_vals = '{32'h11223300, 32'h44556600, 32'h778899AA, 32'hBBCCDD00};
        base = rd_ptr;
        for (int i = 0; i < NPIX; i++) begin
            if (i < 4) pix_mem[(base + i) % 1024] = spec_vals[i];
            else       pix_mem[(base + i) % 1024] = $urandom;
        end
        avail = base + n_avail;
        build_expected(base);
    endtask

    task automatic compare_frame(input string tag, input int obase);
        int n;
        n = out_cnt - obase;
        check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(out_mem[(obase + i) % 4096]), 32'(exp_q[i]));
    endtask

    task automatic wait_done(input string tag, input int d0, input bit rand_full, input bit rand_start);
        int n;
        n = 0;
        while (done_cnt == d0 && n < BUDGET) begin
            @(negedge clk);
            if (rand_full)  out_full = ($urandom_range(0, 2) == 0);
            if (rand_start) start = (done === 1'b1) || ($urandom_range(0, 9) == 0);
            n++;
        end
        out_full = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_idle_wr"}, 32'(out_wr_en), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until_bytes(input string tag, input int target);
        int n;
        n = 0;
        while (out_cnt < target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 32'(out_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, obase, d0, oc, rp, n;

        // Reset state, held and released.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr", 32'(out_wr_en), 32'd0);
        check("rst_rd", 32'(in_rd_en), 32'd0);
        check("rst_din", 32'(out_din), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Frame A: prefilled FIFO, no stalls, first-cycle latency.
        load_frame(base, NPIX);
        obase = out_cnt;
        d0    = done_cnt;
        pulse_start();
        check("a_busy_first", 32'(busy), 32'd1);
`ifdef BMPW_HEADER_EN
        check("a_first_wr", 32'(out_wr_en), 32'd1);
        check("a_first_byte", 32'(out_din), 32'h42);
`else
        check("a_first_pop", 32'(in_rd_en), 32'd1);
        check("a_first_wr", 32'(out_wr_en), 32'd0);
`endif
        wait_done("a", d0, 1'b0, 1'b0);
        compare_frame("a", obase);

        // Frame B: random output back-pressure and start pulses while busy.
        load_frame(base, NPIX);
        obase = out_cnt;
        d0    = done_cnt;
        pulse_start();
        wait_done("b", d0, 1'b1, 1'b1);
        compare_frame("b", obase);

        // Frame C: out_full for 5 cycles with the R byte of pixel 0 pending.
        load_frame(base, NPIX);
        obase = out_cnt;
        d0    = done_cnt;
        pulse_start();
        wait_until_bytes("c", obase + HDR + 2);
        out_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("c_stall_wr", 32'(out_wr_en), 32'd0);
            check("c_stall_din", 32'(out_din), 32'(pix_mem[base % 1024][15:8]));
            check("c_stall_rd", 32'(in_rd_en), 32'd0);
            @(negedge clk);
        end
        out_full = 1'b0;
        wait_done("c", d0, 1'b0, 1'b0);
        compare_frame("c", obase);

        // Frame D: pixel FIFO runs dry before pixel 3.
        load_frame(base, 3);
        obase = out_cnt;
        d0    = done_cnt;
        pulse_start();
        wait_until_bytes("d", obase + HDR + 9);
        @(negedge clk);
        oc = out_cnt;
        for (int i = 0; i < 10; i++) begin
            check("d_wait_rd", 32'(in_rd_en), 32'd0);
            check("d_wait_wr", 32'(out_wr_en), 32'd0);
            check("d_wait_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("d_no_bytes", 32'(out_cnt), 32'(oc));
        avail = base + NPIX;
        wait_done("d", d0, 1'b0, 1'b0);
        compare_frame("d", obase);
        check("d_pops", 32'(rd_ptr - base), 32'(NPIX));

        // Frame E: reset while pixel 1 is being emitted.
        load_frame(base, NPIX);
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (rd_ptr < base + 2 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("e_reached", 32'(rd_ptr >= base + 2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("e_busy", 32'(busy), 32'd0);
        check("e_wr", 32'(out_wr_en), 32'd0);
        check("e_rd", 32'(in_rd_en), 32'd0);
        check("e_done", 32'(done), 32'd0);
        rp = rd_ptr;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("e_no_pop", 32'(rd_ptr), 32'(rp));
        check("e_no_done", 32'(done_cnt - d0), 32'd0);

        // Frame F: fresh frame after the abort starts cleanly.
        load_frame(base, NPIX);
        obase = out_cnt;
        d0    = done_cnt;
        pulse_start();
        wait_done("f", d0, 1'b1, 1'b0);
        compare_frame("f", obase);

        check("no_bad_pop", 32'(bad_pop), 32'd0);
        check("no_wr_while_full", 32'(bad_wr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
